// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner-state encoding,
// requester port identifiers and small helpers relating the two.
package dmem_arb_pkg;

    // Owner state; the encoding is visible on the owner debug output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CORE = 2'b01,
        ST_DBG  = 2'b10
    } owner_e;

    // Requester identity, used for the round-robin "last served" pointer.
    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // The port that did not win last time.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_C) ? PORT_D : PORT_C;
    endfunction

    // Owner state that serves a given port.
    function automatic owner_e port_to_state(input port_e p);
        return (p == PORT_C) ? ST_CORE : ST_DBG;
    endfunction

endpackage

// File: rtl/dmem_arb_mux.sv
// Combinational datapath of the arbiter: turns the current owner into the
// per-port acks, steers the owner's address/data/write-enable onto the
// memory and gates the shared read data back to the port being acked.
module dmem_arb_mux
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          rst_i,
    input  logic [1:0]    state_i,

    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,

    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,

    input  logic [DW-1:0] mem_rd_i,

    output logic          core_ack_o,
    output logic          dbg_ack_o,
    output logic [DW-1:0] core_rdata_o,
    output logic [DW-1:0] dbg_rdata_o,

    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wd_o
);

    // Owner select, ack generation and read-data gating.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;

        // A beat completes only for the owner with its request still up;
        // reset masks both so a dropped burst never writes.
        core_ack_o = ~rst_i & (state_i == ST_CORE) & core_req_i;
        dbg_ack_o  = ~rst_i & (state_i == ST_DBG)  & dbg_req_i;

        case (state_i)
            ST_CORE: begin
                mem_addr_o = core_addr_i;
                mem_wd_o   = core_wdata_i;
                mem_we_o   = core_we_i & core_ack_o;
            end
            ST_DBG: begin
                mem_addr_o = dbg_addr_i;
                mem_wd_o   = dbg_wdata_i;
                mem_we_o   = dbg_we_i & dbg_ack_o;
            end
            default: begin
                // Idle: memory sees a quiet, all-zero bus.
            end
        endcase

        // Memory reads combinationally, so data is valid in the ack cycle.
        core_rdata_o = core_ack_o ? mem_rd_i : '0;
        dbg_rdata_o  = dbg_ack_o  ? mem_rd_i : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory. The core load/store
// path and the debug/loader port share it round-robin per beat; the debug
// port may hold a locked burst, but for at most MAX_BURST beats while the
// core is waiting.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          stall_core,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic [1:0]    owner
);

    // Counter wide enough for 0..MAX_BURST-1 (at least one bit).
    localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    owner_e        state_q, state_d;
    port_e         last_q, last_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    // Datapath: owner steering and ack/rdata generation.
    dmem_arb_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .rst_i        (rst),
        .state_i      (state_q),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .mem_rd_i     (mem_rd),
        .core_ack_o   (core_ack),
        .dbg_ack_o    (dbg_ack),
        .core_rdata_o (core_rdata),
        .dbg_rdata_o  (dbg_rdata),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd)
    );

    assign stall_core = core_req & ~core_ack;
    assign owner      = state_q;

    // Locked debug beats may continue while the core is absent, or while
    // the core has waited fewer than MAX_BURST-1 counted beats.
    logic dbg_keep;
    assign dbg_keep = dbg_req & dbg_lock & (~core_req | (burst_cnt_q < BURST_LAST));

    // Next-owner selection, evaluated every cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req && dbg_req) begin
                    // Tie: the port that did not win last time goes first.
                    state_d = port_to_state(other_port(last_q));
                end else if (core_req) begin
                    state_d = ST_CORE;
                end else if (dbg_req) begin
                    state_d = ST_DBG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CORE: begin
                // Core gets one beat, then yields to a waiting debug port;
                // moving straight across avoids an idle bubble.
                if (dbg_req) begin
                    state_d = ST_DBG;
                end else if (core_req) begin
                    state_d = ST_CORE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBG: begin
                if (dbg_keep) begin
                    state_d = ST_DBG;
                end else if (core_req) begin
                    state_d = ST_CORE;
                end else if (dbg_req) begin
                    state_d = ST_DBG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Burst counter and round-robin pointer updates.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;

        if (core_ack) begin
            last_d = PORT_C;
        end else if (dbg_ack) begin
            last_d = PORT_D;
        end

        // The count only measures how long the core has been held off by a
        // locked burst, so it clears whenever that burst ends.
        if ((state_d != ST_DBG) || !dbg_lock) begin
            burst_cnt_d = '0;
        end else if (dbg_ack && core_req && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_d = burst_cnt_q + CW'(1);
        end
    end

    // State register with synchronous reset; core wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT_D;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a behavioural model of who owns the memory and what it holds.
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_ack, stall_core;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dbg_req, dbg_we, dbg_lock, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .stall_core (stall_core),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .owner      (owner)
    );

    a_ack_excl: assert property (@(posedge clk) !(core_ack && dbg_ack))
        else $error("FAIL ack_exclusive: core_ack and dbg_ack both high");

    // ---------------- memory behind the arbiter ----------------
    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 4)  return 32'hDEAD_BEEF;
        if (i == 12) return 32'h3030_3030;
        return 32'hA500_0000 | DW'(i);
    endfunction

    logic [DW-1:0] bmem    [64];
    logic [DW-1:0] ref_mem [64];
    bit            mem_init = 1'b0;

    assign mem_rd = bmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) bmem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            bmem[mem_addr[7:2]] <= mem_wd;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%s expected=%s at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string ack_char();
        if (core_ack) return "C";
        if (dbg_ack)  return "D";
        return "_";
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // m_own: 0 = nobody, 1 = core, 2 = debug holds the memory this cycle.
    int m_own       = 0;
    int m_streak    = 0;   // debug beats the waiting core has sat through
    bit m_last_core = 1'b0;
    int core_wait   = 0;
    bit c_ack_seen  = 1'b0;
    bit d_ack_seen  = 1'b0;

    always @(negedge clk) begin : model_cmp
        logic          e_cack, e_dack, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_drd;
        int            nxt;
        bit            keep;

        e_cack = !rst && (m_own == 1) && core_req;
        e_dack = !rst && (m_own == 2) && dbg_req;
        e_we   = (e_cack && core_we) || (e_dack && dbg_we);
        e_addr = (m_own == 1) ? core_addr  : (m_own == 2) ? dbg_addr  : '0;
        e_wd   = (m_own == 1) ? core_wdata : (m_own == 2) ? dbg_wdata : '0;
        e_crd  = e_cack ? ref_mem[core_addr[7:2]] : '0;
        e_drd  = e_dack ? ref_mem[dbg_addr[7:2]]  : '0;

        check("owner",      owner,      m_own);
        check("core_ack",   core_ack,   e_cack);
        check("dbg_ack",    dbg_ack,    e_dack);
        check("stall_core", stall_core, core_req && !e_cack);
        check("mem_we",     mem_we,     e_we);
        check("mem_addr",   mem_addr,   e_addr);
        check("mem_wd",     mem_wd,     e_wd);
        check("core_rdata", core_rdata, e_crd);
        check("dbg_rdata",  dbg_rdata,  e_drd);

        // Fairness: the core is never held off longer than one idle
        // bubble plus a full locked burst.
        if (rst) begin
            core_wait = 0;
        end else if (e_cack) begin
            check("core_wait_bound", (core_wait <= MAX_BURST + 1), 1'b1);
            core_wait = 0;
        end else if (core_req) begin
            core_wait++;
        end else begin
            core_wait = 0;
        end

        c_ack_seen = e_cack;
        d_ack_seen = e_dack;
        if (e_we) ref_mem[e_addr[7:2]] = e_cack ? core_wdata : dbg_wdata;

        // Who holds the memory after this edge.
        if (rst) begin
            m_own       = 0;
            m_streak    = 0;
            m_last_core = 1'b0;
        end else begin
            if (m_own == 0) begin
                if (core_req && dbg_req) nxt = m_last_core ? 2 : 1;
                else if (core_req)       nxt = 1;
                else if (dbg_req)        nxt = 2;
                else                     nxt = 0;
            end else if (m_own == 1) begin
                nxt = dbg_req ? 2 : (core_req ? 1 : 0);
            end else begin
                keep = dbg_req && dbg_lock && (!core_req || (m_streak < MAX_BURST - 1));
                nxt  = keep ? 2 : core_req ? 1 : dbg_req ? 2 : 0;
            end
            if (e_cack) m_last_core = 1'b1;
            if (e_dack) m_last_core = 1'b0;
            if (nxt != 2 || !dbg_lock)                             m_streak = 0;
            else if (e_dack && core_req && m_streak < MAX_BURST-1) m_streak++;
            m_own = nxt;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        string s;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        // Reset held with both requesters active and a core write pending.
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h1111_1111;
        dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h44; dbg_wdata  = '0;
        dbg_lock = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_owner",    owner,    2'b00);
            check("rst_core_ack", core_ack, 1'b0);
            check("rst_dbg_ack",  dbg_ack,  1'b0);
            check("rst_mem_we",   mem_we,   1'b0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_bubble", {dbg_ack, core_ack}, 2'b00);
        @(negedge clk);
        check("rel_core_first", {dbg_ack, core_ack}, 2'b01);
        step();
        core_req = 1'b0;
        @(negedge clk);
        check("rel_dbg_next", {dbg_ack, core_ack}, 2'b10);
        step();
        dbg_req = 1'b0;
        step();
        step();

        // Core alone: one bubble, then a beat every cycle.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge clk);
        check("core_first_stall", stall_core, 1'b1);
        check("core_first_noack", core_ack,   1'b0);
        @(negedge clk);
        check("core_ack1",   core_ack,   1'b1);
        check("core_rdata1", core_rdata, 32'hDEAD_BEEF);
        check("core_nostall", stall_core, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("core_stream_ack",   core_ack,   1'b1);
            check("core_stream_stall", stall_core, 1'b0);
        end
        step();
        core_req = 1'b0;
        step();

        // Unlocked contention: strict alternation (core was served last).
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h1;
        dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 32'h24; dbg_wdata  = 32'h2;
        s = "";
        repeat (7) begin
            @(negedge clk);
            s = {s, ack_char()};
        end
        check_str("contend_pattern", s, "_DCDCDC");
        step();
        core_req = 1'b0; dbg_req = 1'b0;
        step();
        step();
        check("contend_mem20", bmem[8], 32'h1);
        check("contend_mem24", bmem[9], 32'h2);

        // Locked debug burst of 8 beats, core arrives at beat 2.
        dbg_lock = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        core_we  = 1'b0; core_addr = 32'h10;
        s = "";
        for (int c = 0; c < 10; c++) begin
            core_req = (c >= 2 && c <= 6);
            dbg_req  = 1'b1;
            @(negedge clk);
            s = {s, ack_char()};
            step();
        end
        check_str("burst_pattern", s, "_DDDDDCDDD");
        dbg_req = 1'b0; core_req = 1'b0; dbg_lock = 1'b0;
        step();
        step();

        // Debug write aborted before its ack.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'h5555_5555;
        @(negedge clk);
        check("abort_idle", owner, 2'b00);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        check("abort_owner_dbg", owner,   2'b10);
        check("abort_noack",     dbg_ack, 1'b0);
        check("abort_no_we",     mem_we,  1'b0);
        step();
        @(negedge clk);
        check("abort_back_idle", owner,    2'b00);
        check("abort_mem30",     bmem[12], 32'h3030_3030);
        step();

        // Reset in the middle of a locked debug burst.
        dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h34; dbg_wdata = 32'h77;
        @(negedge clk);
        step();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge clk);
        check("midrst_beat1", dbg_ack, 1'b1);
        step();
        @(negedge clk);
        check("midrst_beat2", dbg_ack, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dbg_ack",  dbg_ack,  1'b0);
        check("midrst_core_ack", core_ack, 1'b0);
        check("midrst_mem_we",   mem_we,   1'b0);
        step();
        rst = 1'b0; core_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        @(negedge clk);
        check("midrst_owner",     owner,           2'b00);
        check("midrst_burst_cnt", dut.burst_cnt_q, '0);

        // Randomized traffic honouring the hold-until-ack protocol.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (cyc % 64 == 0) dbg_lock = 1'($urandom_range(0, 1));
            if (core_req && !c_ack_seen) begin
                if ($urandom_range(0, 15) == 0) core_req = 1'b0;
            end else begin
                core_req   = ($urandom_range(0, 99) < 60);
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = AW'($urandom_range(0, 63)) << 2;
                core_wdata = $urandom;
            end
            if (dbg_req && !d_ack_seen) begin
                if ($urandom_range(0, 15) == 0) dbg_req = 1'b0;
            end else begin
                dbg_req   = ($urandom_range(0, 99) < 50);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = AW'($urandom_range(0, 63)) << 2;
                dbg_wdata = $urandom;
            end
        end
        step();
        rst = 1'b0; core_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C) and a debug/program-loader port (port D).
- Sits between the core's data-memory signals and the data memory.
  - Presents one address/write-data/write-enable set to memory.
  - Returns read data and a per-port ack.
  - Asserts stall_core while a core access is pending but not served.
- Round-robin per beat, with an optional bounded debug burst lock.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 4, max consecutive locked debug beats while core is waiting; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- core_req  in  1  core access valid.
- core_we  in  1  core write (1) / read (0).
- core_addr  in  AW  core address.
- core_wdata  in  DW  core store data.
- core_ack  out  1  core beat completes this cycle.
- core_rdata  out  DW  core load data, valid with core_ack.
- stall_core  out  1  core_req & ~core_ack.
- dbg_req  in  1  debug access valid.
- dbg_we  in  1  debug write/read.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_lock  in  1  debug requests burst ownership.
- dbg_ack  out  1  debug beat completes.
- dbg_rdata  out  DW  debug read data, valid with dbg_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational read).
- owner  out  2  current state encoding, for debug visibility.

Interface (already decided): one clock, clk; reset rst is synchronous, active-high.

Behaviour:
- States and encoding (owner): IDLE=2'b00, CORE=2'b01, DBG=2'b10. Reset → IDLE, burst_cnt=0, last=D, so core wins the first tie.
- While rst=1: core_ack, dbg_ack and mem_we are forced 0 combinationally; state reloads IDLE at the edge. Reset mid-burst drops the burst with no partial write.
- Transfer rule: a beat completes when the port owns the memory and its req=1.
  - core_ack = (state==CORE) & core_req; dbg_ack = (state==DBG) & dbg_req.
  - Requester holds req/we/addr/wdata stable until ack. Dropping req before ack is legal and aborts with no memory effect.
- Mem mux: the owner's addr/wd drive memory; mem_we = owner_we & owner_ack. In IDLE, addr/wd=0 and mem_we=0.
- Read data: x_rdata = mem_rd when x_ack, else 0. Zero-latency read in the ack cycle.
- Latency: from IDLE, a request is acked on the next cycle (1 bubble). From an owner state, back-to-back beats are acked every cycle with no bubble.
- Next-state logic, evaluated every cycle:
  - IDLE: both requesting → port ≠ last; one requesting → that port; none → IDLE.
  - CORE: if dbg_req → DBG (core gets one beat, then yields); else if core_req → CORE; else IDLE. last=C on a core_ack.
  - DBG:
    - If dbg_req & dbg_lock & (~core_req | burst_cnt < MAX_BURST-1) → DBG.
    - Else if core_req → CORE.
    - Else if dbg_req → DBG.
    - Else IDLE.
    - last=D on a dbg_ack.
- burst_cnt: increments on each dbg_ack while dbg_lock=1 and core_req=1, saturating at MAX_BURST-1. Clears on leaving DBG, or when dbg_lock=0.
- Guarantee: core waits at most MAX_BURST beats when locked, and 1 beat when unlocked.
- A port that requests in the same cycle the other port's req drops is served next cycle via the owner-state transitions (no IDLE detour).
- An ack never goes to a port that is not the owner; both acks high together is illegal. A bench assertion checks this.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner state encoding constants.
  - Port-ID constants PORT_C/PORT_D.
- One natural sub-module, dmem_arb_mux: purely combinational owner-select of addr/wd/we plus rdata gating.
- FSM, burst counter and last pointer stay in dmem_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high and core_we=1 → owner=IDLE, mem_we=0, both acks 0. After release, core acked first on cycle 2.
- Core only: core read addr 0x10, mem_rd=0xDEADBEEF → core_ack the cycle after req and core_rdata=0xDEADBEEF. Continuous req → acks every cycle, stall_core only in the first cycle.
- Contention, unlocked: both req continuously, core writes 0x20 ← 0x1, dbg writes 0x24 ← 0x2 → acks alternate C,D,C,D; mem_we pulses each beat; memory holds both values.
- Locked burst (MAX_BURST=4): dbg_lock=1, dbg 8 beats, core_req raised at beat 2 → dbg acked 4 consecutive beats after core arrival, then 1 core beat, then dbg resumes.
- Abort: dbg_req raised then dropped before ack, with dbg_we=1 and addr 0x30 → no mem_we, memory 0x30 unchanged, owner returns to IDLE.
- Reset mid-burst: assert rst during DBG beat 3 → acks 0 in that cycle, owner=IDLE next cycle, burst_cnt=0.
